n64adv_vinfo_detect: RTL and testbench



---
 rtl/n64adv_vinfo_detect_pkg.sv | 33 +++
 rtl/n64adv_sync_edge.sv | 29 ++
 rtl/n64adv_vinfo_detect.sv | 163 ++++++++++++++++
 tb/tb_n64adv_vinfo_detect.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64adv_vinfo_detect_pkg.sv
// Shared constants for the N64 video-mode detector: FSM encodings, vinfo and sync-nibble bit positions.
// Used by n64adv_vinfo_detect (optional N64ADV_VINFO_LINECNT_EN build adds line-count ports).
package n64adv_vinfo_detect_pkg;

  localparam logic [1:0] ST_NOSIG   = 2'b00;
  localparam logic [1:0] ST_ACQUIRE = 2'b01;
  localparam logic [1:0] ST_LOCKED  = 2'b10;

  localparam int VINFO_PAL_BIT = 1;
  localparam int VINFO_IL_BIT  = 0;

  // VD_SYNC nibble is {VSYNC,CLAMP,HSYNC,CSYNC}, all active low
  localparam int VD_VSYNC_BIT = 3;
  localparam int VD_CLAMP_BIT = 2;
  localparam int VD_HSYNC_BIT = 1;
  localparam int VD_CSYNC_BIT = 0;

  localparam logic [9:0] NTSC_LINES_EVEN = 10'd262;
  localparam logic [9:0] NTSC_LINES_ODD  = 10'd263;
  localparam logic [9:0] PAL_LINES_EVEN  = 10'd312;
  localparam logic [9:0] PAL_LINES_ODD   = 10'd313;

  localparam logic [9:0] LINE_CNT_MAX = 10'h3FF;

  function automatic logic [1:0] make_vinfo(input logic pal, input logic il);
    logic [1:0] v;
    v = 2'b00;
    v[VINFO_PAL_BIT] = pal;
    v[VINFO_IL_BIT]  = il;
    return v;
  endfunction

endpackage

// File: rtl/n64adv_sync_edge.sv
// Nibble-qualified falling-edge extractor for the active-low VSYNC/HSYNC bits of the N64 sync nibble.
// Levels are only sampled on nVDSYNC=0 cycles, so data cycles never create false edges.
module n64adv_sync_edge (
  input  logic VCLK,
  input  logic nVRST,
  input  logic nVDSYNC,
  input  logic vsync_n,
  input  logic hsync_n,
  output logic h_fall,
  output logic v_fall
);

  logic prev_h;
  logic prev_v;

  assign h_fall = !nVDSYNC & prev_h & !hsync_n;
  assign v_fall = !nVDSYNC & prev_v & !vsync_n;

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      prev_h <= 1'b1;
      prev_v <= 1'b1;
    end else if (!nVDSYNC) begin
      prev_h <= hsync_n;
      prev_v <= vsync_n;
    end
  end

endmodule

// File: rtl/n64adv_vinfo_detect.sv
// Video-mode detector: counts lines per field, derives {pal, interlaced} and field parity, debounced lock.
// Define N64ADV_VINFO_LINECNT_EN to expose the measured line count (lines_o) and its saturation flag.
module n64adv_vinfo_detect
  import n64adv_vinfo_detect_pkg::*;
#(
  parameter logic [9:0]  PAL_THRESH    = 10'd288,
  parameter logic [2:0]  STABLE_FIELDS = 3'd3,
  parameter logic [20:0] TIMEOUT       = 21'h1F_FFFF
) (
  input  logic       VCLK,
  input  logic       nVRST,
  input  logic       nVDSYNC,
  input  logic [3:0] VD_SYNC,
  output logic       vsync_fall_o,
  output logic [1:0] vinfo_o,
  output logic       field_o,
  output logic       vinfo_valid_o
`ifdef N64ADV_VINFO_LINECNT_EN
  ,
  output logic [9:0] lines_o,
  output logic       lines_sat_o
`endif
);

  logic        h_fall;
  logic        v_fall;
  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [9:0]  line_cnt;
  logic [9:0]  last_lines;
  logic [9:0]  prev_lines;
  logic [2:0]  agree_cnt;
  logic [2:0]  agree_next;
  logic [2:0]  run_len;
  logic [20:0] to_cnt;
  logic [1:0]  prev_cand;
  logic [1:0]  cand;
  logic [1:0]  vinfo_next;
  logic        valid_next;
  logic        cand_pal;
  logic        cand_il;
  logic        timeout;
  logic        eval;
  logic        unused_sync;

  n64adv_sync_edge u_sync_edge (
    .VCLK    (VCLK),
    .nVRST   (nVRST),
    .nVDSYNC (nVDSYNC),
    .vsync_n (VD_SYNC[VD_VSYNC_BIT]),
    .hsync_n (VD_SYNC[VD_HSYNC_BIT]),
    .h_fall  (h_fall),
    .v_fall  (v_fall)
  );

  assign unused_sync = ^{VD_SYNC[VD_CLAMP_BIT], VD_SYNC[VD_CSYNC_BIT]};

  // Candidate is formed from the values last_lines/prev_lines take on at this v_fall edge
  assign cand_pal = line_cnt > PAL_THRESH;
  assign cand_il  = (line_cnt != last_lines) && (last_lines != 10'd0);
  assign cand     = make_vinfo(cand_pal, cand_il);

  assign timeout  = !v_fall && (to_cnt == TIMEOUT - 21'd1);
  assign eval     = v_fall && ((state == ST_ACQUIRE) || (state == ST_LOCKED));
  assign run_len  = (cand == prev_cand) ? agree_cnt + 3'd1 : 3'd1;

  always_comb begin
    state_next = state;
    agree_next = agree_cnt;
    vinfo_next = vinfo_o;
    valid_next = vinfo_valid_o;
    if (timeout) begin
      state_next = ST_NOSIG;
      agree_next = 3'd0;
      valid_next = 1'b0;
    end else begin
      case (state)
        ST_NOSIG: begin
          if (v_fall) state_next = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (v_fall) begin
            agree_next = run_len;
            if (run_len == STABLE_FIELDS) begin
              vinfo_next = cand;
              valid_next = 1'b1;
              state_next = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (v_fall) begin
            if (cand == vinfo_o) begin
              agree_next = STABLE_FIELDS;
            end else begin
              // prev_cand equals vinfo_o whenever agree_cnt is full, so run_len restarts at 1 here
              agree_next = run_len;
              if (run_len == STABLE_FIELDS) vinfo_next = cand;
            end
          end
        end
        default: begin
          state_next = ST_NOSIG;
          agree_next = 3'd0;
          valid_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      state         <= ST_NOSIG;
      line_cnt      <= 10'd0;
      last_lines    <= 10'd0;
      prev_lines    <= 10'd0;
      agree_cnt     <= 3'd0;
      to_cnt        <= 21'd0;
      prev_cand     <= 2'b00;
      vsync_fall_o  <= 1'b0;
      vinfo_o       <= 2'b00;
      field_o       <= 1'b0;
      vinfo_valid_o <= 1'b0;
    end else begin
      state         <= state_next;
      agree_cnt     <= agree_next;
      vinfo_o       <= vinfo_next;
      vinfo_valid_o <= valid_next;
      vsync_fall_o  <= v_fall;
      if (timeout) begin
        line_cnt   <= 10'd0;
        last_lines <= 10'd0;
        prev_lines <= 10'd0;
        to_cnt     <= 21'd0;
      end else if (v_fall) begin
        last_lines <= line_cnt;
        prev_lines <= last_lines;
        line_cnt   <= h_fall ? 10'd1 : 10'd0;
        to_cnt     <= 21'd0;
      end else begin
        to_cnt <= to_cnt + 21'd1;
        if (h_fall && (line_cnt != LINE_CNT_MAX)) line_cnt <= line_cnt + 10'd1;
      end
      if (eval) begin
        prev_cand <= cand;
        field_o   <= cand_il & line_cnt[0];
      end
    end
  end

`ifdef N64ADV_VINFO_LINECNT_EN
  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      lines_o     <= 10'd0;
      lines_sat_o <= 1'b0;
    end else if (eval) begin
      lines_o     <= line_cnt;
      lines_sat_o <= (line_cnt == LINE_CNT_MAX);
    end
  end
`endif

endmodule

// File: tb/tb_n64adv_vinfo_detect.sv
// Randomized bench for n64adv_vinfo_detect with a field-level reference model and per-cycle compare.
// Build with N64ADV_VINFO_LINECNT_EN defined to also cover lines_o / lines_sat_o.
module tb_n64adv_vinfo_detect;

  localparam int TO = 4000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       nvd;
  logic [3:0] vd;
  logic       vsync_fall_o;
  logic [1:0] vinfo_o;
  logic       field_o;
  logic       vinfo_valid_o;
`ifdef N64ADV_VINFO_LINECNT_EN
  logic [9:0] lines_o;
  logic       lines_sat_o;
`endif

  always #5 clk = ~clk;

  n64adv_vinfo_detect #(
    .PAL_THRESH    (10'd288),
    .STABLE_FIELDS (3'd3),
    .TIMEOUT       (21'(TO))
  ) dut (
    .VCLK          (clk),
    .nVRST         (rst_n),
    .nVDSYNC       (nvd),
    .VD_SYNC       (vd),
    .vsync_fall_o  (vsync_fall_o),
    .vinfo_o       (vinfo_o),
    .field_o       (field_o),
    .vinfo_valid_o (vinfo_valid_o)
`ifdef N64ADV_VINFO_LINECNT_EN
    ,
    .lines_o       (lines_o),
    .lines_sat_o   (lines_sat_o)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: field lengths and a window of recent per-field candidates
  int        m_cnt, m_last, m_idle, m_lines;
  bit        m_acq, m_lock, m_field, m_vs, m_pv, m_ph, m_sat;
  bit [1:0]  m_vinfo;
  bit [1:0]  cq[$];

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_cnt = 0; m_last = 0; m_idle = 0; m_lines = 0;
    m_acq = 0; m_lock = 0; m_field = 0; m_vs = 0; m_sat = 0;
    m_pv = 1; m_ph = 1; m_vinfo = 2'b00;
    cq.delete();
  endfunction

  function automatic void model_step();
    bit vf, hf;
    int len;
    bit [1:0] c;
    vf = !nvd && m_pv && !vd[3];
    hf = !nvd && m_ph && !vd[1];
    if (!nvd) begin
      m_pv = vd[3];
      m_ph = vd[1];
    end
    m_vs = vf;
    if (vf) begin
      len = (m_cnt > 1023) ? 1023 : m_cnt;
      if (m_acq) begin
        c[1] = (len > 288);
        c[0] = (len != m_last) && (m_last != 0);
        m_field = c[0] && (len % 2 == 1);
        m_lines = len;
        m_sat = (m_cnt >= 1023);
        cq.push_back(c);
        if (cq.size() > 3) void'(cq.pop_front());
        if (cq.size() == 3 && cq[0] == c && cq[1] == c && (!m_lock || m_vinfo != c)) begin
          m_vinfo = c;
          m_lock = 1;
        end
      end
      m_acq = 1;
      m_last = len;
      m_cnt = hf ? 1 : 0;
      m_idle = 0;
    end else begin
      if (hf) m_cnt++;
      m_idle++;
      if (m_idle == TO) begin
        m_acq = 0; m_lock = 0; cq.delete();
        m_cnt = 0; m_last = 0; m_idle = 0;
      end
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("vsync_fall", 10'(vsync_fall_o), 10'(m_vs));
        chk("vinfo", 10'(vinfo_o), 10'(m_vinfo));
        chk("valid", 10'(vinfo_valid_o), 10'(m_lock));
        chk("field", 10'(field_o), 10'(m_field));
`ifdef N64ADV_VINFO_LINECNT_EN
        chk("lines", lines_o, 10'(m_lines));
        chk("lines_sat", 10'(lines_sat_o), 10'(m_sat));
`endif
      end
    end
  end

  task automatic put(input logic nv, input logic [3:0] d);
    @(negedge clk);
    nvd = nv;
    vd  = d;
  endtask

  task automatic gap();
    if ($urandom_range(0, 3) == 0) put(1'b1, 4'($urandom));
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      put(1'b0, 4'b1111);
      gap();
      put(1'b0, 4'b1101);
      gap();
    end
  endtask

  task automatic vpulse(input bit sim);
    put(1'b0, 4'b1111);
    put(1'b0, sim ? 4'b0101 : 4'b0111);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    nvd = 1'b1;
    vd = 4'hF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int len_tab[6];
    len_tab = '{262, 263, 312, 313, 240, 300};
    rst_n = 1'b0;
    nvd = 1'b1;
    vd = 4'hF;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_valid", 10'(vinfo_valid_o), 10'd0);
    chk("rst_vinfo", 10'(vinfo_o), 10'd0);
    chk("rst_field", 10'(field_o), 10'd0);
    chk("rst_vsync", 10'(vsync_fall_o), 10'd0);
    rst_n = 1'b1;

    // NTSC 240p
    repeat (3) begin vpulse(0); lines(263); end
    chk("240p_prelock_valid", 10'(vinfo_valid_o), 10'd0);
    vpulse(0);
    @(negedge clk);
    chk("240p_lock_valid", 10'(vinfo_valid_o), 10'd1);
    chk("240p_lock_vinfo", 10'(vinfo_o), 10'd0);
    chk("240p_pulse", 10'(vsync_fall_o), 10'd1);
    chk("240p_field", 10'(field_o), 10'd0);
    @(negedge clk);
    chk("240p_pulse_width", 10'(vsync_fall_o), 10'd0);
    repeat (2) begin lines(263); vpulse(0); end

    // NTSC 480i
    do_reset();
    vpulse(0);
    repeat (2) begin lines(262); vpulse(0); lines(263); vpulse(0); end
    @(negedge clk);
    chk("480i_vinfo", 10'(vinfo_o), 10'd1);
    chk("480i_valid", 10'(vinfo_valid_o), 10'd1);
    chk("480i_field_long", 10'(field_o), 10'd1);
    lines(262); vpulse(0);
    @(negedge clk);
    chk("480i_field_short", 10'(field_o), 10'd0);

    // PAL 576i then switch to 240p while locked
    do_reset();
    vpulse(0);
    repeat (2) begin lines(312); vpulse(0); lines(313); vpulse(0); end
    @(negedge clk);
    chk("pal_vinfo", 10'(vinfo_o), 10'd3);
    chk("pal_field", 10'(field_o), 10'd1);
    repeat (2) begin lines(263); vpulse(0); end
    @(negedge clk);
    chk("switch_hold_vinfo", 10'(vinfo_o), 10'd3);
    chk("switch_hold_valid", 10'(vinfo_valid_o), 10'd1);
    repeat (2) begin lines(263); vpulse(0); end
    @(negedge clk);
    chk("switch_new_vinfo", 10'(vinfo_o), 10'd0);
    chk("switch_new_valid", 10'(vinfo_valid_o), 10'd1);

    // Signal loss: nibbles stop right after the last v_fall
    nvd = 1'b1;
    repeat (TO - 1) @(negedge clk);
    chk("timeout_before", 10'(vinfo_valid_o), 10'd1);
    @(negedge clk);
    chk("timeout_drop", 10'(vinfo_valid_o), 10'd0);
    repeat (20) @(negedge clk);
    vpulse(0);
    repeat (3) begin lines(263); vpulse(0); end
    @(negedge clk);
    chk("relock_valid", 10'(vinfo_valid_o), 10'd1);

    // Simultaneous VSYNC/HSYNC fall starts a field already at one line
    vpulse(1); lines(262); vpulse(0);
    @(negedge clk);
    chk("sim_vinfo", 10'(vinfo_o), 10'd0);
    chk("sim_valid", 10'(vinfo_valid_o), 10'd1);

    // Asynchronous reset in the middle of a field
    lines(50);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 10'(vinfo_valid_o), 10'd0);
    chk("async_rst_vinfo", 10'(vinfo_o), 10'd0);
    chk("async_rst_vsync", 10'(vsync_fall_o), 10'd0);
    @(negedge clk);
    nvd = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized field lengths and sync alignments
    vpulse(0);
    for (int f = 0; f < 14; f++) begin
      int n;
      bit s;
      n = ($urandom_range(0, 2) == 0) ? len_tab[$urandom_range(0, 5)] : len_tab[f % 2 + 2 * ($urandom_range(0, 1))];
      s = ($urandom_range(0, 3) == 0);
      lines(s ? n - 1 : n);
      vpulse(s);
    end

`ifdef N64ADV_VINFO_LINECNT_EN
    do_reset();
    vpulse(0); lines(263); vpulse(0); lines(1100); vpulse(0);
    @(negedge clk);
    chk("sat_lines", lines_o, 10'd1023);
    chk("sat_flag", 10'(lines_sat_o), 10'd1);
    lines(263); vpulse(0);
    @(negedge clk);
    chk("unsat_flag", 10'(lines_sat_o), 10'd0);
    chk("unsat_lines", lines_o, 10'd263);
`endif

    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
